// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int CNT_W          = $clog2(DEF_FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; a pop on a full FIFO frees room for a
// same-cycle push, and flush empties it in one cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  parameter int  CW      = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  entry_t        wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output entry_t        rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and in-order instruction fetch with credit-limited issue,
// branch redirect/flush and discard of stale in-flight responses.
//
//   state   | meaning
//   S_IDLE  | first cycle after reset release, no request issued
//   S_FETCH | issuing requests while credit is available
//   S_STALL | fetch_en low, issue halted; in-flight responses still land
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              PC_STEP    = 1,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int CW = cnt_w(FIFO_DEPTH);
  // Discards can pile up across several back-to-back redirects on a slow memory.
  localparam int DW = CW + 4;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [DW-1:0]     disc_q, disc_d;
  logic              br_hold_q;

  logic              granted;
  logic              resp_live;
  logic              resp_drop;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     occ;
  logic [CW:0]       in_use;
  entry_t            wentry;
  entry_t            head;

  assign in_use    = {1'b0, occ} + {1'b0, out_q};
  assign imem_req  = (state_q == S_FETCH) && fetch_en && !br_hold_q &&
                     (in_use < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc_q;
  assign granted   = imem_req && imem_gnt;
  assign resp_drop = imem_rvalid && (disc_q != '0);
  assign resp_live = imem_rvalid && (disc_q == '0);
  assign push      = resp_live && !branch_valid;
  assign pop       = if_valid && if_ready;
  assign wentry    = '{pc: resp_pc_q, instr: imem_rdata};

  assign if_valid  = !fifo_empty;
  assign if_pc     = head.pc;
  assign if_instr  = head.instr;
  assign pc_out    = fetch_pc_q;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t),
    .CW      (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .flush_i (branch_valid),
    .rdata_o (head),
    .count_o (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (!fetch_en) state_d = S_STALL;
      S_STALL: if (fetch_en)  state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CW'(granted) - CW'(resp_live);
    disc_d     = disc_q - DW'(resp_drop);
    if (granted)   fetch_pc_d = fetch_pc_q + STEP;
    if (resp_live) resp_pc_d  = resp_pc_q + STEP;
    // Everything still live, including a same-cycle grant, becomes stale.
    if (branch_valid) begin
      fetch_pc_d = branch_target;
      resp_pc_d  = branch_target;
      disc_d     = disc_q - DW'(resp_drop) + DW'(out_d);
      out_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      br_hold_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      br_hold_q  <= branch_valid;
    end
  end

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!reset)
    imem_rvalid |-> ((out_q != '0) || (disc_q != '0)));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (push && fifo_full) |-> pop);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench for pc_fetch_unit: in-order memory model plus a
// sequence-level reference of which PCs must be issued and delivered.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [31:0] W_RESET_PC = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, fetch_en, branch_valid;
  logic [31:0] branch_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr, pc_out;

  logic        w_reset, w_fetch_en, w_branch_valid, w_gnt, w_rvalid, w_if_ready;
  logic [31:0] w_branch_target, w_rdata;
  logic        w_req, w_if_valid;
  logic [31:0] w_addr, w_if_pc, w_if_instr, w_pc_out;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .pc_out(pc_out)
  );

  pc_fetch_unit #(.RESET_PC(W_RESET_PC)) dut_wrap (
    .clk(clk), .reset(w_reset), .fetch_en(w_fetch_en),
    .branch_valid(w_branch_valid), .branch_target(w_branch_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .if_valid(w_if_valid), .if_ready(w_if_ready), .if_pc(w_if_pc),
    .if_instr(w_if_instr), .pc_out(w_pc_out)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  int          cyc = 0;
  int          last_due = 0;
  int          min_lat = 1, max_lat = 1, gnt_pct = 100;
  logic [31:0] exp_issue, exp_pop;
  int          owed, grants, pops;
  logic        prev_branch, obs_valid, obs_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_issue   = 32'h0;
    exp_pop     = 32'h0;
    owed        = 0;
    pops        = 0;
    grants      = 0;
    prev_branch = 1'b0;
    last_due    = cyc;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    branch_valid = 1'b0;
    fetch_en     = 1'b1;
    if_ready     = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: called at a negedge with this cycle's inputs already driven.
  task automatic step();
    mreq_t r;
    int    due;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(r.addr);
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    #1;
    obs_valid = if_valid;
    obs_req   = imem_req;
    if (prev_branch) begin
      checks++;
      if (imem_req !== 1'b0) begin
        failures++;
        $display("FAIL req_after_branch: imem_req=%b want 0", imem_req);
      end
    end
    if (imem_req) begin
      checks++;
      if (owed >= DEPTH) begin
        failures++;
        $display("FAIL credit: request issued with %0d words owed, limit %0d", owed, DEPTH);
      end
    end
    if (if_valid && if_ready) begin
      checks++;
      if (if_pc !== exp_pop || if_instr !== mem_word(exp_pop)) begin
        failures++;
        $display("FAIL deliver: got pc=%h instr=%h want pc=%h instr=%h",
                 if_pc, if_instr, exp_pop, mem_word(exp_pop));
      end
      exp_pop = exp_pop + 32'd1;
      pops++;
      owed--;
    end
    if (imem_req && imem_gnt) begin
      checks++;
      if (imem_addr !== exp_issue) begin
        failures++;
        $display("FAIL issue_addr: got %h want %h", imem_addr, exp_issue);
      end
      due = cyc + $urandom_range(max_lat, min_lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: imem_addr, due: due});
      exp_issue = exp_issue + 32'd1;
      grants++;
      owed++;
    end
    if (branch_valid) begin
      exp_issue = branch_target;
      exp_pop   = branch_target;
      owed      = 0;
    end
    prev_branch = branch_valid;
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    min_lat = 1; max_lat = 1; gnt_pct = 100;
    fetch_en = 1'b1; if_ready = 1'b1; branch_valid = 1'b0; branch_target = 32'h0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc_out: got %h want 0", pc_out); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    int first;
    first = -1;
    reset = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (obs_valid && first < 0) first = i;
    end
    checks++;
    if (first != 4) begin
      failures++;
      $display("FAIL first_valid_latency: got %0d cycles want 3", first - 1);
    end
    checks++;
    if (pops != 27) begin
      failures++;
      $display("FAIL stream_throughput: got %0d pops want 27", pops);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    if_ready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    checks++; if (grants != DEPTH) begin failures++; $display("FAIL bp_grants: got %0d want %0d", grants, DEPTH); end
    checks++; if (obs_req !== 1'b0) begin failures++; $display("FAIL bp_req: got %b want 0", obs_req); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      failures++; $display("FAIL bp_head: got valid=%b pc=%h want valid=1 pc=0", if_valid, if_pc);
    end
    if_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    checks++; if (grants <= DEPTH) begin failures++; $display("FAIL bp_resume: got %0d grants want more than %0d", grants, DEPTH); end
  endtask

  task automatic test_branch();
    min_lat = 3; max_lat = 3;
    do_reset();
    step();
    step();
    step();
    gnt_pct = 0;
    branch_valid = 1'b1;
    branch_target = 32'h40;
    step();
    branch_valid = 1'b0;
    gnt_pct = 100;
    step();
    step();
    checks++; if (obs_req !== 1'b1) begin failures++; $display("FAIL branch_req_resume: got %b want 1", obs_req); end
    for (int i = 0; i < 12; i++) step();
    checks++; if (pops < 2) begin failures++; $display("FAIL branch_delivered: got %0d pops want at least 2", pops); end
    min_lat = 1; max_lat = 1;
  endtask

  task automatic test_stall();
    int guard;
    guard = 0;
    do_reset();
    while (exp_issue != 32'd5 && guard < 40) begin
      step();
      guard++;
    end
    checks++; if (guard >= 40) begin failures++; $display("FAIL stall_timeout: issue addr %h want 5", exp_issue); end
    fetch_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (obs_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b want 0", obs_req); end
    end
    checks++; if (pops != 5) begin failures++; $display("FAIL stall_delivered: got %0d want 5", pops); end
    checks++; if (pc_out !== 32'd5) begin failures++; $display("FAIL stall_pc_out: got %h want 5", pc_out); end
    fetch_en = 1'b1;
    grants = 0;
    for (int i = 0; i < 6; i++) step();
    checks++; if (grants == 0) begin failures++; $display("FAIL stall_resume: got 0 grants want >0"); end
  endtask

  task automatic test_random();
    min_lat = 1; max_lat = 4; gnt_pct = 70;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if_ready      = ($urandom_range(99) < 75);
      fetch_en      = ($urandom_range(99) < 90);
      branch_valid  = ($urandom_range(99) < 5);
      branch_target = $urandom();
      step();
    end
    branch_valid = 1'b0;
    checks++; if (pops < 50) begin failures++; $display("FAIL random_progress: got %0d pops want at least 50", pops); end
  endtask

  task automatic test_reset_mid();
    min_lat = 1; max_lat = 3; gnt_pct = 100;
    do_reset();
    for (int i = 0; i < 15; i++) step();
    reset = 1'b0;
    model_reset();
    #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b want 0", if_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req: got %b want 0", imem_req); end
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL mid_rst_pc: got %h want 0", pc_out); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++; if (pops == 0) begin failures++; $display("FAIL mid_rst_restart: got 0 pops want >0"); end
  endtask

  task automatic test_wrap();
    int          n;
    logic [31:0] e;
    n = 0;
    w_fetch_en = 1'b1; w_gnt = 1'b1; w_if_ready = 1'b1;
    w_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (w_req && w_gnt) begin
        e = W_RESET_PC + 32'(n);
        checks++;
        if (w_addr !== e) begin failures++; $display("FAIL wrap_addr: got %h want %h", w_addr, e); end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n != DEPTH) begin failures++; $display("FAIL wrap_grants: got %0d want %0d", n, DEPTH); end
    e = W_RESET_PC + 32'(DEPTH);
    checks++; if (w_pc_out !== e) begin failures++; $display("FAIL wrap_pc_out: got %h want %h", w_pc_out, e); end
  endtask

  initial begin
    reset = 1'b1; w_reset = 1'b1;
    fetch_en = 1'b1; branch_valid = 1'b0; branch_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b1;
    w_fetch_en = 1'b0; w_branch_valid = 1'b0; w_branch_target = 32'h0;
    w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0; w_if_ready = 1'b0;
    #2;
    reset = 1'b0; w_reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_stall();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the free-running PC counter that drives CPU_V0.
- Owns the program counter and issues in-order requests to instruction memory with a request/grant/response handshake.
- Buffers returned words in a prefetch FIFO and hands {pc, instr} pairs to decode with valid/ready.
- Supports stall (fetch_en low), branch redirect with flush, and discard of stale in-flight responses.

Parameters:
- ADDR_W, 32: PC / memory address width.
- DATA_W, 32: instruction width.
- PC_STEP, 1: PC increment per instruction (word addressing; 4 for byte addressing).
- FIFO_DEPTH, 4: prefetch entries; power of two, ≥2.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  1 = issue new requests; 0 = stall issue.
- branch_valid  in  1  redirect strobe, one cycle.
- branch_target  in  ADDR_W  redirect PC.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address (current fetch PC).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in order, ≥1 cycle after grant.
- imem_rdata  in  DATA_W  response word.
- if_valid  out  1  FIFO head valid.
- if_ready  in  1  decode accepts head.
- if_pc  out  ADDR_W  PC of head instruction.
- if_instr  out  DATA_W  head instruction.
- pc_out  out  ADDR_W  current fetch PC (debug).

Behaviour:
- Reset (reset=0, async): state=S_IDLE; fetch_pc=resp_pc=RESET_PC; FIFO empty; outstanding=discard=0; imem_req=0; if_valid=0; if_pc/if_instr=0; pc_out=RESET_PC.
- FSM:
  - S_IDLE → S_FETCH the first cycle after reset release (no request issued in S_IDLE).
  - S_FETCH → S_STALL when fetch_en=0.
  - S_STALL → S_FETCH when fetch_en=1.
  - branch_valid does not change state.
- Issue:
  - imem_req=1 iff state=S_FETCH, fetch_en=1, and occupancy+live_outstanding < FIFO_DEPTH (registered values; a same-cycle pop frees credit next cycle).
  - imem_addr=fetch_pc.
  - On req&&gnt: fetch_pc += PC_STEP (mod 2^ADDR_W, wraps silently); live_outstanding++.
  - imem_req stays asserted, address stable, until gnt.
- Response:
  - On rvalid with discard>0: discard--, data dropped.
  - Otherwise: push {resp_pc, rdata}; resp_pc += PC_STEP; live_outstanding--.
  - The credit rule guarantees no overflow; an rvalid with no outstanding request is a protocol error (assertion).
- Output: if_valid = FIFO non-empty; pop on if_valid&&if_ready; first-word latency = grant-to-rvalid + 1 cycle (FIFO write, then visible).
- Branch (branch_valid=1), takes priority:
  - fetch_pc=resp_pc=branch_target next cycle.
  - FIFO flushed; a same-cycle pop is still considered consumed.
  - discard += live_outstanding, including a request granted in the same cycle.
  - live_outstanding=0; a same-cycle non-discarded rvalid is also dropped.
  - imem_req deasserts for exactly one cycle after the branch.
- Simultaneous push and pop on a full FIFO: pop first, push accepted (no loss).
- fetch_en=0 mid-stream: no new requests; in-flight responses still land in the FIFO.
- reset asserted mid-operation: all state is cleared immediately; pending memory responses after release are the memory's responsibility (memory is reset on the same net).

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {S_IDLE, S_FETCH, S_STALL}.
  - fetch_entry_t struct {pc, instr}.
  - Counter width localparam CNT_W = $clog2(FIFO_DEPTH)+1.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t, with push, pop, flush, count, full and empty.
- Top module holds the FSM, PC registers, and the outstanding/discard counters.

Test Plan:
- Reset release, gnt=1 always, 1-cycle memory returning mem[a]=a+0x100, if_ready=1 → if_pc 0,1,2,3… with if_instr 0x100,0x101…; first if_valid 3 cycles after release.
- if_ready=0 with FIFO_DEPTH=4 → exactly 4 requests granted, then imem_req=0; FIFO holds pc 0..3; raising if_ready resumes at addr 4.
- 3-cycle memory latency, branch_valid with branch_target=0x40 while 2 requests are in flight → both responses discarded; next if_pc=0x40, then 0x41; no stale data appears.
- fetch_en=0 at fetch_pc=5 → no request for addr 5 until fetch_en=1; instructions 0..4 still delivered.
- RESET_PC=32'hFFFF_FFFE, PC_STEP=1 → addresses FFFF_FFFE, FFFF_FFFF, 0000_0000 (wrap).
- reset pulsed low mid-stream → same cycle if_valid=0, imem_req=0; after release, fetch restarts at RESET_PC.
